// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    OP_NEG    = 3'b000,
    OP_INC    = 3'b001,
    OP_ADDC   = 3'b010,
    OP_ADDSHR = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_CAT    = 3'b110,
    OP_ZERO   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational signed ALU: opcode table plus sign and zero flags.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]              i_opc,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic                    i_cin,
  output logic signed [WIDTH-1:0] o_res,
  output logic                    o_neg,
  output logic                    o_zer
);

  logic signed [WIDTH-1:0] w_res;

  // Evaluate the selected function; all arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_res unassigned (no latch).
    w_res = '0;
    case (op_e'(i_opc))
      OP_NEG:    w_res = -i_a;
      OP_INC:    w_res = i_a + WIDTH'(1);
      OP_ADDC:   w_res = i_a + i_b + WIDTH'(i_cin);
      OP_ADDSHR: w_res = i_a + (i_b >>> 1);
      OP_AND:    w_res = i_a & i_b;
      OP_OR:     w_res = i_a | i_b;
      OP_CAT:    w_res = {i_a[WIDTH/2-1:0], i_b[WIDTH/2-1:0]};
      OP_ZERO:   w_res = '0;
      default:   w_res = '0;
    endcase
  end

  assign o_res = w_res;
  assign o_neg = w_res[WIDTH-1];
  assign o_zer = (w_res == '0);

endmodule

// File: rtl/alu_rr_scheduler.sv
// Two-channel round-robin front end for a shared signed ALU.
// One op every three cycles: IDLE (grant) -> EXEC (compute) -> RESP (ack).
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [2:0]              opc0,
  input  logic signed [WIDTH-1:0] a0,
  input  logic signed [WIDTH-1:0] b0,
  input  logic                    cin0,
  input  logic                    req1,
  input  logic [2:0]              opc1,
  input  logic signed [WIDTH-1:0] a1,
  input  logic signed [WIDTH-1:0] b1,
  input  logic                    cin1,
  output logic                    ack0,
  output logic                    ack1,
  output logic signed [WIDTH-1:0] res,
  output logic                    neg,
  output logic                    zer,
  output logic                    busy,
  output logic                    gnt_id
);

  state_e                  r_state;
  logic                    r_last;
  logic [2:0]              r_opc;
  logic signed [WIDTH-1:0] r_a;
  logic signed [WIDTH-1:0] r_b;
  logic                    r_cin;

  logic                    w_any;
  logic                    w_win;
  logic signed [WIDTH-1:0] w_alu_res;
  logic                    w_alu_neg;
  logic                    w_alu_zer;

  // Round-robin pick: a lone requester wins; on contention the channel not granted last time wins.
  assign w_any = req0 | req1;
  assign w_win = (req0 & req1) ? ~r_last : req1;

  // Capture the winner's operands on the grant edge; later input changes cannot reach the in-flight op.
  always_ff @(posedge clk) begin
    // NOTE: operand registers have no reset; they are always loaded at grant before EXEC reads them.
    if (r_state == IDLE && w_any) begin
      r_opc <= w_win ? opc1 : opc0;
      r_a   <= w_win ? a1   : a0;
      r_b   <= w_win ? b1   : b0;
      r_cin <= w_win ? cin1 : cin0;
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .i_opc (r_opc),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_cin (r_cin),
    .o_res (w_alu_res),
    .o_neg (w_alu_neg),
    .o_zer (w_alu_zer)
  );

  // Control FSM with registered result, flags, ack pulses and busy; reset overrides every transition.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      res     <= '0;
      neg     <= 1'b0;
      zer     <= 1'b1;
      busy    <= 1'b0;
      gnt_id  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt_id  <= w_win;
            r_last  <= w_win;
            busy    <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          res     <= w_alu_res;
          neg     <= w_alu_neg;
          zer     <= w_alu_zer;
          ack0    <= ~gnt_id;
          ack1    <= gnt_id;
          r_state <= RESP;
        end
        RESP: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed scenarios with literal
// expectations, then randomized protocol-legal traffic, all compared each
// cycle against a transaction-level model.
module tb_alu_rr_scheduler;

  logic               clk;
  logic               rst;
  logic               req0, req1;
  logic [2:0]         opc0, opc1;
  logic [15:0]        a0, b0, a1, b1;
  logic               cin0, cin1;
  logic               ack0, ack1;
  logic [15:0]        res;
  logic               neg, zer, busy, gnt_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model state: edge counter, next edge at which a grant may happen,
  // edge at which the pending result appears, and the pending result.
  int          k          = 0;
  int          m_next_free = 0;
  int          m_ack_at   = -1;
  logic [15:0] m_pend     = '0;
  bit          m_last     = 1;
  logic        e_ack0 = 0, e_ack1 = 0, e_neg = 0, e_zer = 1, e_busy = 0, e_gnt = 0;
  logic [15:0] e_res = '0;

  alu_rr_scheduler #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .opc0   (opc0),
    .a0     (a0),
    .b0     (b0),
    .cin0   (cin0),
    .req1   (req1),
    .opc1   (opc1),
    .a1     (a1),
    .b1     (b1),
    .cin1   (cin1),
    .ack0   (ack0),
    .ack1   (ack1),
    .res    (res),
    .neg    (neg),
    .zer    (zer),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode table using plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input logic [2:0] opc, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    int as, bs, au, bu, r;
    as = int'($signed(a));
    bs = int'($signed(b));
    au = int'(a);
    bu = int'(b);
    case (opc)
      3'd0:    r = -as;
      3'd1:    r = as + 1;
      3'd2:    r = as + bs + int'(cin);
      3'd3:    r = as + (bs - (bs & 1)) / 2;
      3'd4:    r = au & bu;
      3'd5:    r = au | bu;
      3'd6:    r = (au % 256) * 256 + (bu % 256);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_update();
    bit win;
    k++;
    if (rst) begin
      e_ack0 = 0; e_ack1 = 0; e_res = '0; e_neg = 0; e_zer = 1; e_busy = 0; e_gnt = 0;
      m_last = 1; m_ack_at = -1; m_next_free = k + 1;
    end else begin
      e_ack0 = 0;
      e_ack1 = 0;
      if (k == m_ack_at) begin
        e_res = m_pend;
        e_neg = m_pend[15];
        e_zer = (m_pend == 16'd0);
        if (e_gnt) e_ack1 = 1; else e_ack0 = 1;
      end
      if (k >= m_next_free && (req0 || req1)) begin
        win         = (req0 && req1) ? !m_last : req1;
        m_pend      = win ? ref_alu(opc1, a1, b1, cin1) : ref_alu(opc0, a0, b0, cin0);
        e_gnt       = win;
        m_last      = win;
        m_ack_at    = k + 1;
        m_next_free = k + 3;
      end
      e_busy = (k + 1 < m_next_free);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack0",   ack0,   e_ack0);
      check("ack1",   ack1,   e_ack1);
      check("res",    res,    e_res);
      check("neg",    neg,    e_neg);
      check("zer",    zer,    e_zer);
      check("busy",   busy,   e_busy);
      check("gnt_id", gnt_id, e_gnt);
    end
  end

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1; req0 = 0; req1 = 0;
    opc0 = '0; a0 = '0; b0 = '0; cin0 = 0;
    opc1 = '0; a1 = '0; b1 = '0; cin1 = 0;
    step();
    chk_en = 1;
    step();
    check("reset_busy", busy, 0);
    check("reset_zer",  zer,  1);
    check("reset_res",  res,  0);
    check("reset_ack",  {ack1, ack0}, 0);
    rst = 0;
    step();

    // Single op on ch0: 5+7+1.
    req0 = 1; opc0 = 3'd2; a0 = 16'd5; b0 = 16'd7; cin0 = 1;
    step();
    check("single_busy", busy, 1);
    step();
    check("single_ack0", ack0, 1);
    check("single_ack1", ack1, 0);
    check("single_res",  res,  16'd13);
    check("single_flag", {neg, zer}, 2'b00);
    req0 = 0;
    step();
    check("single_ack0_drop", ack0, 0);

    // Arithmetic shift on ch1, then back-to-back wrap with req held.
    req1 = 1; opc1 = 3'd3; a1 = 16'd100; b1 = 16'hFFF8; cin1 = 0;
    step(); step();
    check("shr_ack1", ack1, 1);
    check("shr_res",  res,  16'd96);
    opc1 = 3'd1; a1 = 16'h7FFF;
    step(); step(); step();
    check("wrap_res", res, 16'h8000);
    check("wrap_neg", neg, 1);
    req1 = 0;
    step();

    // Reset during EXEC abandons the op; then ch0 wins first contention.
    req0 = 1; opc0 = 3'd2; a0 = 16'd3; b0 = 16'd4; cin0 = 0;
    step();
    rst = 1; req0 = 0;
    step();
    check("rst_mid_ack",  {ack1, ack0}, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_res",  res,  0);
    check("rst_mid_zer",  zer,  1);
    rst = 0;
    req0 = 1; opc0 = 3'd1; a0 = 16'd41;
    req1 = 1; opc1 = 3'd7; a1 = 16'h5555; b1 = 16'h1111;
    step();
    check("post_rst_gnt", gnt_id, 0);
    step();
    check("post_rst_res", res, 16'd42);
    req0 = 0;
    step(); step(); step();
    check("post_rst_ack1", ack1, 1);
    check("post_rst_zer",  zer,  1);
    req1 = 0;
    step();

    // Contention from reset: alternation 0,1,0,1.
    rst = 1;
    req0 = 1; opc0 = 3'd0; a0 = 16'd1; b0 = 16'd0; cin0 = 0;
    req1 = 1; opc1 = 3'd6; a1 = 16'h1234; b1 = 16'hABCD; cin1 = 0;
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step(); step();
      check("rr_gnt",  gnt_id, i % 2);
      check("rr_ack0", ack0,   (i % 2 == 0) ? 1 : 0);
      check("rr_res",  res,    (i % 2 == 0) ? 16'hFFFF : 16'h34CD);
      check("rr_neg",  neg,    (i % 2 == 0) ? 1 : 0);
      if (i == 3) begin req0 = 0; req1 = 0; end
      step();
    end

    // Zero results.
    req0 = 1; opc0 = 3'd7; a0 = 16'h1234; b0 = 16'h5678; cin0 = 1;
    step(); step();
    check("zero_res",  res, 0);
    check("zero_flag", {neg, zer}, 2'b01);
    opc0 = 3'd5; a0 = 16'h00F0; b0 = 16'h0F00;
    step(); step(); step();
    check("or_res", res, 16'h0FF0);
    opc0 = 3'd4;
    step(); step(); step();
    check("and_res", res, 0);
    check("and_zer", zer, 1);
    req0 = 0;
    step();

    // Operand change after the grant edge has no effect.
    req0 = 1; opc0 = 3'd2; a0 = 16'd10; b0 = 16'd20; cin0 = 0;
    step();
    a0 = 16'd999; b0 = 16'd1; opc0 = 3'd7;
    step();
    check("latched_res", res, 16'd30);
    req0 = 0;
    step();

    // Randomized protocol-legal traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!req0) begin
        if ($urandom_range(0, 1) == 1) begin
          req0 = 1; opc0 = 3'($urandom_range(0, 7)); a0 = rnd_op(); b0 = rnd_op();
          cin0 = 1'($urandom_range(0, 1));
        end
      end else if (e_ack0) begin
        if ($urandom_range(0, 1) == 1) req0 = 0;
        else begin
          opc0 = 3'($urandom_range(0, 7)); a0 = rnd_op(); b0 = rnd_op();
          cin0 = 1'($urandom_range(0, 1));
        end
      end else if (e_busy && !e_gnt && !e_ack0 && !e_ack1) begin
        a0 = rnd_op(); b0 = rnd_op();
      end
      if (!req1) begin
        if ($urandom_range(0, 1) == 1) begin
          req1 = 1; opc1 = 3'($urandom_range(0, 7)); a1 = rnd_op(); b1 = rnd_op();
          cin1 = 1'($urandom_range(0, 1));
        end
      end else if (e_ack1) begin
        if ($urandom_range(0, 1) == 1) req1 = 0;
        else begin
          opc1 = 3'($urandom_range(0, 7)); a1 = rnd_op(); b1 = rnd_op();
          cin1 = 1'($urandom_range(0, 1));
        end
      end else if (e_busy && e_gnt && !e_ack0 && !e_ack1) begin
        a1 = rnd_op(); b1 = rnd_op();
      end
      step();
    end

    rst = 0; req0 = 0; req1 = 0;
    step(); step(); step();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one 16-bit signed ALU datapath between two requesters (ch0, ch1) under round-robin arbitration.
- Each requester presents opcode, operands and carry-in with a req/ack handshake. The block latches the winner's operands, runs the ALU on registered operands, and returns a registered result with flags and a one-cycle ack.
- Sits between the control units that issue arithmetic/logic ops and the shared ALU core.

Parameters:
- WIDTH, 16, datapath width. Opcode 110 concatenation uses the WIDTH/2 low halves.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0  input  1  ch0 request; held high with stable operands until ack0
- opc0  input  3  ch0 opcode
- a0  input  WIDTH  ch0 operand A, signed
- b0  input  WIDTH  ch0 operand B, signed
- cin0  input  1  ch0 carry-in
- req1, opc1, a1, b1, cin1  input  1/3/WIDTH/WIDTH/1  ch1, same meaning as ch0
- ack0  output  1  one-cycle pulse: ch0 result valid on res/neg/zer
- ack1  output  1  one-cycle pulse: ch1 result valid
- res  output  WIDTH  registered ALU result, signed
- neg  output  1  registered res[WIDTH-1]
- zer  output  1  registered (res == 0)
- busy  output  1  high whenever state != IDLE
- gnt_id  output  1  channel currently or most recently granted

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ack0=ack1=0, res=0, neg=0, zer=1, busy=0, gnt_id=0, last_grant=1 (so ch0 wins the first contention).
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that channel.
  - Both req: grant the channel != last_grant.
  - On grant: register opc/a/b/cin of the winner into op registers, set gnt_id and last_grant, go to EXEC.
- EXEC: ALU core evaluates the registered operands. At the clock edge, res/neg/zer load, ack[gnt_id] <= 1, go to RESP.
- RESP: ack high for exactly this cycle, then ack <= 0 and go to IDLE.
- Latency: req sampled in an IDLE cycle -> ack high two cycles later. Throughput is one op per 3 cycles.
- Requester rules:
  - Deassert req on the edge after seeing ack, unless it issues a new op.
  - A req still high in IDLE is treated as a new request.
  - Operands must stay stable only until the grant edge. Changes after grant do not affect the in-flight op.
- res/neg/zer hold their value between ops. Only EXEC updates them.
- ALU functions (modulo 2^WIDTH, two's complement, overflow wraps silently):
  - 000: -A
  - 001: A+1
  - 010: A+B+cin
  - 011: A+(B>>>1), arithmetic shift
  - 100: A&B
  - 101: A|B
  - 110: {A[WIDTH/2-1:0], B[WIDTH/2-1:0]}
  - 111: 0
- Fairness: a channel holding req continuously cannot be starved. With both held high, grants alternate 0,1,0,1.
- A req arriving while busy waits for IDLE; no request is lost or queued beyond the held level.
- Reset mid-operation: the in-flight op is abandoned, no ack is issued, and all state returns to reset values on that edge.
- Reset has priority over every transition.

Decomposition:
- Package alu_sched_pkg:
  - opcode enum: OP_NEG, OP_INC, OP_ADDC, OP_ADDSHR, OP_AND, OP_OR, OP_CAT, OP_ZERO
  - state enum: IDLE, EXEC, RESP
  - WIDTH default constant
- Sub-module alu_core: purely combinational, implements the opcode table plus neg/zer. Instantiated once and fed from the op registers.

Test Plan:
- Single op: ch0 opc=010, a=5, b=7, cin=1 -> ack0 two cycles after sampling, res=13, neg=0, zer=0, ack1 never high.
- Arithmetic shift and wrap: ch1 opc=011, a=100, b=-8 -> res=96. Then ch1 opc=001, a=0x7FFF -> res=0x8000, neg=1.
- Contention: req0 and req1 both high from reset, ch0 opc=000 a=1, ch1 opc=110 a=0x1234 b=0xABCD, both held after ack:
  - grants ch0, ch1, ch0, ch1
  - results alternate 0xFFFF (neg=1) and 0x34CD
- Zero result: opc=111 with any operands -> res=0, zer=1, neg=0. Then opc=100 with a=0x00F0, b=0x0F00 -> res=0, zer=1.
- Reset mid-op: assert rst during EXEC -> no ack, next cycle busy=0, res=0, zer=1. A subsequent simultaneous request is granted to ch0 first.
- Operand change after grant: change a0 in EXEC -> res reflects the values latched at the grant edge.
